// File: rtl/fp_unpack_issue.sv
// fp_unpack_issue: operand-pair issue buffer in front of an FP add/sub datapath.
// Buffers packed single-precision operand pairs in a circular buffer and presents
// the head entry already unpacked into sign/exponent/fraction plus a one-hot class.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   in_valid, in_ready   producer handshake; in_ready = (count < DEPTH)
//   op_a, op_b, opcode_i packed operands and add(0)/sub(1) opcode to enqueue
//   out_valid, out_ready datapath handshake; out_valid = (count != 0)
//   sign*, exp*, sig*    unpacked fields of the head operands (zero when empty)
//   opcode, tag          head opcode and push-order sequence tag
//   class1, class2       one-hot {snan, qnan, inf, denorm, zero}; zero means normal
//   count                number of occupied entries
module fp_unpack_issue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [31:0]             op_a,
    input  logic [31:0]             op_b,
    input  logic                    opcode_i,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sign1,
    output logic                    sign2,
    output logic [7:0]              exp1,
    output logic [7:0]              exp2,
    output logic [22:0]             sig1,
    output logic [22:0]             sig2,
    output logic                    opcode,
    output logic [4:0]              class1,
    output logic [4:0]              class2,
    output logic [3:0]              tag,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef logic [PtrW-1:0] ptr_t;

    logic [31:0] mem_a   [DEPTH];
    logic [31:0] mem_b   [DEPTH];
    logic        mem_op  [DEPTH];
    logic [3:0]  mem_tag [DEPTH];

    ptr_t            wr_ptr_q;
    ptr_t            rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [3:0]      tag_q;

    logic push;
    logic pop;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    function automatic logic [4:0] classify(input logic [7:0] e, input logic [22:0] f);
        logic [4:0] c;
        c = 5'b00000;
        if (e == 8'd0) begin
            c = (f == 23'd0) ? 5'b00001 : 5'b00010;
        end else if (e == 8'hff) begin
            if (f == 23'd0)   c = 5'b00100;
            else if (f[22])   c = 5'b01000;
            else              c = 5'b10000;
        end
        return c;
    endfunction

    assign in_ready  = (count_q < CntW'(DEPTH));
    assign out_valid = (count_q != '0);
    // A pop while full frees a slot only after the edge, so it never enables a push.
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            tag_q    <= '0;
        end else begin
            if (push) begin
                mem_a[wr_ptr_q]   <= op_a;
                mem_b[wr_ptr_q]   <= op_b;
                mem_op[wr_ptr_q]  <= opcode_i;
                mem_tag[wr_ptr_q] <= tag_q;
                wr_ptr_q          <= ptr_inc(wr_ptr_q);
                tag_q             <= tag_q + 4'd1;
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    // Head decode reads registered storage only: no combinational in-to-out path.
    always_comb begin
        sign1  = 1'b0;
        sign2  = 1'b0;
        exp1   = '0;
        exp2   = '0;
        sig1   = '0;
        sig2   = '0;
        opcode = 1'b0;
        class1 = '0;
        class2 = '0;
        tag    = '0;
        if (out_valid) begin
            sign1  = mem_a[rd_ptr_q][31];
            exp1   = mem_a[rd_ptr_q][30:23];
            sig1   = mem_a[rd_ptr_q][22:0];
            sign2  = mem_b[rd_ptr_q][31];
            exp2   = mem_b[rd_ptr_q][30:23];
            sig2   = mem_b[rd_ptr_q][22:0];
            opcode = mem_op[rd_ptr_q];
            tag    = mem_tag[rd_ptr_q];
            class1 = classify(mem_a[rd_ptr_q][30:23], mem_a[rd_ptr_q][22:0]);
            class2 = classify(mem_b[rd_ptr_q][30:23], mem_b[rd_ptr_q][22:0]);
        end
    end

endmodule

// File: tb/tb_fp_unpack_issue.sv
// Self-checking bench for fp_unpack_issue: directed sequences, a classification
// table and randomized traffic checked against a queue-based reference model.
module tb_fp_unpack_issue;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        opcode_i;
    logic        out_valid;
    logic        out_ready;
    logic        sign1, sign2;
    logic [7:0]  exp1, exp2;
    logic [22:0] sig1, sig2;
    logic        opcode;
    logic [4:0]  class1, class2;
    logic [3:0]  tag;
    logic [2:0]  count;

    fp_unpack_issue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .opcode_i  (opcode_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sign1     (sign1),
        .sign2     (sign2),
        .exp1      (exp1),
        .exp2      (exp2),
        .sig1      (sig1),
        .sig2      (sig2),
        .opcode    (opcode),
        .class1    (class1),
        .class2    (class2),
        .tag       (tag),
        .count     (count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        int          tag;
    } entry_t;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  cls;
    } class_vec_t;

    entry_t model_q[$];
    int     model_tag;
    int     n_tests;
    int     n_fail;

    wire [78:0] dut_fields = {sign1, exp1, sig1, sign2, exp2, sig2, opcode,
                              class1, class2, tag};

    // Reference classification from field values as plain integers.
    function automatic logic [4:0] ref_class(input logic [31:0] x);
        int unsigned e;
        int unsigned f;
        e = (int'(x) >>> 23) & 255;
        f = x % (1 << 23);
        if (e == 0) return (f == 0) ? 5'b00001 : 5'b00010;
        if (e == 255) begin
            if (f == 0) return 5'b00100;
            return (f >= (1 << 22)) ? 5'b01000 : 5'b10000;
        end
        return 5'b00000;
    endfunction

    function automatic logic [78:0] ref_fields(input entry_t en);
        logic [78:0] r;
        r = {1'(en.a / 32'h8000_0000), 8'((en.a / (1 << 23)) % 256), 23'(en.a % (1 << 23)),
             1'(en.b / 32'h8000_0000), 8'((en.b / (1 << 23)) % 256), 23'(en.b % (1 << 23)),
             en.op, ref_class(en.a), ref_class(en.b), 4'(en.tag % 16)};
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock with the given inputs; updates the model and compares every output.
    task automatic cycle(input logic rst, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic op, input logic rdy);
        bit     do_push;
        bit     do_pop;
        entry_t e;
        reset     = rst;
        in_valid  = v;
        op_a      = a;
        op_b      = b;
        opcode_i  = op;
        out_ready = rdy;
        do_push = !rst && v && (model_q.size() < DEPTH);
        do_pop  = !rst && rdy && (model_q.size() != 0);
        @(posedge clk);
        #1;
        if (rst) begin
            model_q.delete();
            model_tag = 0;
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) begin
                e.a = a;
                e.b = b;
                e.op = op;
                e.tag = model_tag;
                model_q.push_back(e);
                model_tag = (model_tag + 1) % 16;
            end
        end
        check("ctrl", 128'({out_valid, in_ready, count}),
              128'({model_q.size() != 0, model_q.size() < DEPTH, 3'(model_q.size())}));
        check("fields", 128'(dut_fields),
              (model_q.size() != 0) ? 128'(ref_fields(model_q[0])) : 128'd0);
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] s;
        logic [31:0] f;
        s = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0;
        f = $urandom % (1 << 23);
        case ($urandom_range(0, 5))
            0:       return s;
            1:       return s | ((f == 0) ? 32'd1 : f);
            2:       return s | 32'h7F80_0000;
            3:       return s | 32'h7F80_0000 | ((f == 0) ? 32'd5 : f);
            default: return s | (32'($urandom_range(1, 254)) << 23) | f;
        endcase
    endfunction

    class_vec_t cvec[9];

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        model_tag = 0;
        cvec[0] = '{32'h0000_0000, 5'b00001};
        cvec[1] = '{32'h0000_0001, 5'b00010};
        cvec[2] = '{32'h7F80_0000, 5'b00100};
        cvec[3] = '{32'h7FC0_0000, 5'b01000};
        cvec[4] = '{32'h7F80_0001, 5'b10000};
        cvec[5] = '{32'h3F80_0000, 5'b00000};
        cvec[6] = '{32'hFF80_0000, 5'b00100};
        cvec[7] = '{32'h807F_FFFF, 5'b00010};
        cvec[8] = '{32'h7FBF_FFFF, 5'b10000};

        // Reset state.
        cycle(1, 1, 32'h1234_5678, 32'h0, 0, 1);
        cycle(1, 0, 32'h0, 32'h0, 0, 0);
        cycle(0, 0, 32'h0, 32'h0, 0, 0);

        // Single push, checked against hand values.
        cycle(0, 1, 32'h3F80_0000, 32'hC000_0000, 1, 0);
        check("single_valid", 128'(out_valid), 128'd1);
        check("single_a", 128'({sign1, exp1, sig1}), 128'({1'b0, 8'h7F, 23'd0}));
        check("single_b", 128'({sign2, exp2, sig2}), 128'({1'b1, 8'h80, 23'd0}));
        check("single_misc", 128'({opcode, class1, class2, tag, count}),
              128'({1'b1, 5'd0, 5'd0, 4'd0, 3'd1}));
        cycle(0, 0, 32'h0, 32'h0, 0, 1);

        // Classification table.
        for (int i = 0; i < 9; i++) begin
            cycle(0, 1, cvec[i].a, cvec[i].a ^ 32'h8000_0000, 0, 0);
            check($sformatf("class1_%0d", i), 128'(class1), 128'(cvec[i].cls));
            check($sformatf("class2_%0d", i), 128'(class2), 128'(cvec[i].cls));
            cycle(0, 0, 32'h0, 32'h0, 0, 1);
        end

        // Fill to full, then refused pushes with and without a same-cycle pop.
        cycle(1, 0, 32'h0, 32'h0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, 32'(i + 1) << 23, 32'h4000_0000, 0, 0);
        end
        check("full_ready", 128'({in_ready, count}), 128'({1'b0, 3'd4}));
        cycle(0, 1, 32'hDEAD_BEEF, 32'h0, 1, 0);
        check("full_hold", 128'({count, tag}), 128'({3'd4, 4'd0}));
        cycle(0, 1, 32'hDEAD_BEEF, 32'h0, 1, 1);
        check("full_pop", 128'({count, tag, in_ready}), 128'({3'd3, 4'd1, 1'b1}));

        // Mid-stream reset with three entries, then the next push carries tag 0.
        cycle(1, 1, 32'h4040_0000, 32'h0, 0, 1);
        check("flush", 128'({count, out_valid, in_ready}), 128'({3'd0, 1'b0, 1'b1}));
        cycle(0, 1, 32'h4040_0000, 32'h0, 0, 0);
        check("flush_tag", 128'({tag, count}), 128'({4'd0, 3'd1}));

        // Streaming: one accept and one retire per cycle, tags wrap.
        cycle(1, 0, 32'h0, 32'h0, 0, 0);
        cycle(0, 1, 32'h3F80_0000, 32'h3F80_0000, 0, 1);
        for (int i = 1; i <= 20; i++) begin
            check($sformatf("stream_%0d", i), 128'({tag, count}), 128'({4'((i - 1) % 16), 3'd1}));
            cycle(0, (i < 20), 32'(i) << 23, 32'h3F80_0000, 0, 1);
        end
        check("stream_end", 128'(count), 128'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 70), rand_op(),
                  rand_op(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < ((i < 300) ? 35 : 75)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
